// File: rtl/router_pkg.sv
// Shared constants and helpers for the router datapath register stage.
package router_pkg;
  localparam int DATA_W = 8;
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  function automatic logic addr_ok(input logic [1:0] addr);
    return (addr != ADDR_INVALID);
  endfunction
endpackage

// File: rtl/router_reg_if.sv
// Source byte stream, FSM state strobes and FIFO-side results of the router register stage.
interface router_reg_if #(parameter int DATA_W = router_pkg::DATA_W);
  logic              pkt_vd;
  logic [DATA_W-1:0] din;
  logic              fifo_full;
  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              rst_in_reg;
  logic [DATA_W-1:0] dout;
  logic              parity_done;
  logic              low_pkt_vd;
  logic              err;

  modport master (
    output pkt_vd, din, fifo_full, detect_add, lfd_state, ld_state,
           laf_state, full_state, rst_in_reg,
    input  dout, parity_done, low_pkt_vd, err
  );

  modport slave (
    input  pkt_vd, din, fifo_full, detect_add, lfd_state, ld_state,
           laf_state, full_state, rst_in_reg,
    output dout, parity_done, low_pkt_vd, err
  );
endinterface

// File: rtl/router_parity_acc.sv
// Byte-wise XOR parity accumulator with captured packet parity and a one-shot mismatch compare.
module router_parity_acc #(parameter int DATA_W = 8) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear,
  input  logic              xor_en,
  input  logic [DATA_W-1:0] xor_data,
  input  logic              cap_en,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              err_clr,
  output logic              parity_done,
  output logic              err
);
  logic [DATA_W-1:0] int_par_r;
  logic [DATA_W-1:0] pkt_par_r;
  logic              done_q_r;

  // Accumulate, capture, and compare once on the rising edge of parity_done.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      int_par_r   <= {DATA_W{1'b0}};
      pkt_par_r   <= {DATA_W{1'b0}};
      parity_done <= 1'b0;
      done_q_r    <= 1'b0;
      err         <= 1'b0;
    end else begin
      if (clear)
        int_par_r <= {DATA_W{1'b0}};
      else if (xor_en)
        int_par_r <= int_par_r ^ xor_data;

      if (cap_en) begin
        pkt_par_r   <= cap_data;
        parity_done <= 1'b1;
      end else if (clear) begin
        parity_done <= 1'b0;
      end

      done_q_r <= parity_done;

      if (parity_done && !done_q_r)
        err <= (int_par_r != pkt_par_r);
      else if (err_clr)
        err <= 1'b0;
    end
  end
endmodule

// File: rtl/router_reg.sv
// Router datapath register stage: header capture, FIFO write byte mux, full-stall hold and parity check.
module router_reg
  import router_pkg::*;
#(
  parameter int DATA_W = router_pkg::DATA_W
) (
  input logic         clk,
  input logic         rstn,
  router_reg_if.slave bus
);
  logic [DATA_W-1:0] hdr_r;
  logic [DATA_W-1:0] hold_r;
  logic              hold_is_par_r;
  logic [DATA_W-1:0] dout_r;
  logic              low_pkt_vd_r;

  logic              xor_en_s;
  logic [DATA_W-1:0] xor_data_s;
  logic              cap_en_s;
  logic [DATA_W-1:0] cap_data_s;
  logic              parity_done_s;
  logic              err_s;

  // Select which byte feeds the running parity and which byte is the packet parity.
  always_comb begin
    xor_en_s   = 1'b0;
    xor_data_s = {DATA_W{1'b0}};
    cap_en_s   = 1'b0;
    cap_data_s = {DATA_W{1'b0}};
    if (bus.lfd_state) begin
      xor_en_s   = 1'b1;
      xor_data_s = hdr_r;
    end else if (bus.ld_state && bus.pkt_vd && !bus.fifo_full) begin
      xor_en_s   = 1'b1;
      xor_data_s = bus.din;
    end else if (bus.laf_state && !hold_is_par_r) begin
      xor_en_s   = 1'b1;
      xor_data_s = hold_r;
    end else begin
      xor_en_s   = 1'b0;
    end
    if (bus.ld_state && !bus.pkt_vd && !bus.fifo_full) begin
      cap_en_s   = 1'b1;
      cap_data_s = bus.din;
    end else if (bus.laf_state && hold_is_par_r) begin
      cap_en_s   = 1'b1;
      cap_data_s = hold_r;
    end else begin
      cap_en_s   = 1'b0;
    end
  end

  // Header, FIFO byte, stall hold and short-packet flag registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hdr_r         <= {DATA_W{1'b0}};
      hold_r        <= {DATA_W{1'b0}};
      hold_is_par_r <= 1'b0;
      dout_r        <= {DATA_W{1'b0}};
      low_pkt_vd_r  <= 1'b0;
    end else begin
      if (bus.detect_add && bus.pkt_vd && addr_ok(bus.din[1:0]))
        hdr_r <= bus.din;

      if (bus.lfd_state)
        dout_r <= hdr_r;
      else if (bus.ld_state && !bus.fifo_full)
        dout_r <= bus.din;
      else if (bus.laf_state)
        dout_r <= hold_r;

      // A byte arriving into a full FIFO is parked; it remembers whether it was the parity byte.
      if (bus.ld_state && bus.fifo_full) begin
        hold_r        <= bus.din;
        hold_is_par_r <= !bus.pkt_vd;
      end

      if (bus.ld_state && !bus.pkt_vd)
        low_pkt_vd_r <= 1'b1;
      else if (bus.rst_in_reg)
        low_pkt_vd_r <= 1'b0;
    end
  end

  router_parity_acc #(.DATA_W(DATA_W)) u_parity (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (bus.detect_add),
    .xor_en     (xor_en_s),
    .xor_data   (xor_data_s),
    .cap_en     (cap_en_s),
    .cap_data   (cap_data_s),
    .err_clr    (bus.detect_add && bus.pkt_vd),
    .parity_done(parity_done_s),
    .err        (err_s)
  );

  assign bus.dout        = dout_r;
  assign bus.parity_done = parity_done_s;
  assign bus.low_pkt_vd  = low_pkt_vd_r;
  assign bus.err         = err_s;
endmodule

// File: tb/tb_router_reg.sv
// Directed bench for router_reg: FSM strobes are driven by hand, expected values are hand-computed.
module tb_router_reg;
  logic clk = 1'b0;
  logic rstn;
  int   total = 0;
  int   bad   = 0;

  localparam logic [5:0] DA   = 6'b100000;
  localparam logic [5:0] LFD  = 6'b010000;
  localparam logic [5:0] LD   = 6'b001000;
  localparam logic [5:0] LAF  = 6'b000100;
  localparam logic [5:0] FS   = 6'b000010;
  localparam logic [5:0] RIR  = 6'b000001;
  localparam logic [5:0] IDLE = 6'b000000;

  router_reg_if bus ();

  router_reg dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus and return 1 time unit after the rising edge.
  task automatic cyc(input logic [7:0] d, input logic vd, input logic full, input logic [5:0] st);
    bus.din       = d;
    bus.pkt_vd    = vd;
    bus.fifo_full = full;
    {bus.detect_add, bus.lfd_state, bus.ld_state,
     bus.laf_state, bus.full_state, bus.rst_in_reg} = st;
    @(posedge clk);
    #1;
  endtask

  // Header 0D, payload 11 22 33, then the given parity byte, through check_parity_error.
  task automatic send_pkt(input logic [7:0] par, input logic exp_err, input string t);
    cyc(8'h0D, 1'b1, 1'b0, DA);
    check_val({t, "_err_hdr"}, 32'(bus.err), 32'h0);
    cyc(8'h11, 1'b1, 1'b0, LFD);
    check_val({t, "_dout_hdr"}, 32'(bus.dout), 32'h0D);
    cyc(8'h11, 1'b1, 1'b0, LD);
    check_val({t, "_dout_p0"}, 32'(bus.dout), 32'h11);
    cyc(8'h22, 1'b1, 1'b0, LD);
    check_val({t, "_dout_p1"}, 32'(bus.dout), 32'h22);
    cyc(8'h33, 1'b1, 1'b0, LD);
    check_val({t, "_dout_p2"}, 32'(bus.dout), 32'h33);
    check_val({t, "_done_early"}, 32'(bus.parity_done), 32'h0);
    cyc(par, 1'b0, 1'b0, LD);
    check_val({t, "_dout_par"}, 32'(bus.dout), 32'(par));
    check_val({t, "_done"}, 32'(bus.parity_done), 32'h1);
    check_val({t, "_low"}, 32'(bus.low_pkt_vd), 32'h1);
    cyc(par, 1'b0, 1'b0, IDLE);
    check_val({t, "_err_lp"}, 32'(bus.err), 32'(exp_err));
    cyc(8'h00, 1'b0, 1'b0, RIR);
    check_val({t, "_err_cpe"}, 32'(bus.err), 32'(exp_err));
    check_val({t, "_low_clr"}, 32'(bus.low_pkt_vd), 32'h0);
  endtask

  initial begin
    rstn = 1'b0;
    cyc(8'h00, 1'b0, 1'b0, IDLE);
    cyc(8'h00, 1'b0, 1'b0, IDLE);
    check_val("rst_dout", 32'(bus.dout), 32'h0);
    check_val("rst_done", 32'(bus.parity_done), 32'h0);
    check_val("rst_low", 32'(bus.low_pkt_vd), 32'h0);
    check_val("rst_err", 32'(bus.err), 32'h0);
    rstn = 1'b1;

    send_pkt(8'h0D, 1'b0, "good");
    send_pkt(8'hFF, 1'b1, "badpar");

    // Address 2'b11 is ignored: hdr keeps 0D, but err still clears on the header cycle.
    cyc(8'h0F, 1'b1, 1'b0, DA);
    check_val("inv_err_clr", 32'(bus.err), 32'h0);
    cyc(8'h11, 1'b1, 1'b0, LFD);
    check_val("inv_hdr_kept", 32'(bus.dout), 32'h0D);

    // FIFO full while the second payload byte is presented.
    cyc(8'h0D, 1'b1, 1'b0, DA);
    cyc(8'h11, 1'b1, 1'b0, LFD);
    cyc(8'h11, 1'b1, 1'b0, LD);
    check_val("stall_p0", 32'(bus.dout), 32'h11);
    cyc(8'h22, 1'b1, 1'b1, LD);
    check_val("stall_hold_ld", 32'(bus.dout), 32'h11);
    cyc(8'h22, 1'b1, 1'b1, FS);
    check_val("stall_hold_fs", 32'(bus.dout), 32'h11);
    cyc(8'h22, 1'b1, 1'b0, LAF);
    check_val("stall_laf", 32'(bus.dout), 32'h22);
    cyc(8'h33, 1'b1, 1'b0, LD);
    check_val("stall_p2", 32'(bus.dout), 32'h33);
    cyc(8'h0D, 1'b0, 1'b0, LD);
    check_val("stall_done", 32'(bus.parity_done), 32'h1);
    cyc(8'h0D, 1'b0, 1'b0, IDLE);
    cyc(8'h00, 1'b0, 1'b0, RIR);
    check_val("stall_err", 32'(bus.err), 32'h0);

    // FIFO full while the parity byte is presented.
    cyc(8'h0D, 1'b1, 1'b0, DA);
    cyc(8'h11, 1'b1, 1'b0, LFD);
    cyc(8'h11, 1'b1, 1'b0, LD);
    cyc(8'h22, 1'b1, 1'b0, LD);
    cyc(8'h33, 1'b1, 1'b0, LD);
    cyc(8'h0D, 1'b0, 1'b1, LD);
    check_val("pstall_dout", 32'(bus.dout), 32'h33);
    check_val("pstall_nodone", 32'(bus.parity_done), 32'h0);
    check_val("pstall_low", 32'(bus.low_pkt_vd), 32'h1);
    cyc(8'h0D, 1'b0, 1'b1, FS);
    check_val("pstall_fs_nodone", 32'(bus.parity_done), 32'h0);
    cyc(8'h0D, 1'b0, 1'b0, LAF);
    check_val("pstall_laf_dout", 32'(bus.dout), 32'h0D);
    check_val("pstall_laf_done", 32'(bus.parity_done), 32'h1);
    cyc(8'h0D, 1'b0, 1'b0, IDLE);
    cyc(8'h00, 1'b0, 1'b0, RIR);
    check_val("pstall_err", 32'(bus.err), 32'h0);

    // Set of low_pkt_vd wins over a simultaneous clear.
    cyc(8'h5A, 1'b0, 1'b1, LD | RIR);
    check_val("low_set_wins", 32'(bus.low_pkt_vd), 32'h1);
    cyc(8'h00, 1'b0, 1'b0, RIR);
    check_val("low_clear", 32'(bus.low_pkt_vd), 32'h0);

    // Reset after two payload bytes, then a clean packet.
    cyc(8'h0D, 1'b1, 1'b0, DA);
    cyc(8'h11, 1'b1, 1'b0, LFD);
    cyc(8'h11, 1'b1, 1'b0, LD);
    cyc(8'h22, 1'b1, 1'b0, LD);
    check_val("mid_pre_dout", 32'(bus.dout), 32'h22);
    rstn = 1'b0;
    cyc(8'h33, 1'b1, 1'b0, LD);
    check_val("mid_rst_dout", 32'(bus.dout), 32'h0);
    check_val("mid_rst_done", 32'(bus.parity_done), 32'h0);
    check_val("mid_rst_low", 32'(bus.low_pkt_vd), 32'h0);
    check_val("mid_rst_err", 32'(bus.err), 32'h0);
    rstn = 1'b1;
    send_pkt(8'h0D, 1'b0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
